// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment driver:
// the hex glyph table and the output polarity helper.
package seg7_pkg;

  // Active-high {g,f,e,d,c,b,a} glyph for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] pol8(input logic [7:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to active-high {dp,g..a} pattern.
// blank_i suppresses a-g only; the decimal point always follows dp_i.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] pat_o
);

  assign pat_o = {dp_i, blank_i ? 7'h00 : hex7(nib_i)};

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scanner with frame-synchronous shadow load,
// leading-zero blanking, 16-level PWM brightness and an all-off guard per slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 25000000,
  parameter int SCAN_HZ        = 4000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  input  logic [3:0]              brightness_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    frame_o
);

  localparam int P       = CLK_HZ / SCAN_HZ;
  localparam int CW      = $clog2(P);
  localparam int EW      = CW + 1;
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int ON_UNIT = (P - BLANK_CYCLES) / 16;

  localparam logic [CW-1:0]         SLOT_LAST = CW'(P - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF   = pol8(8'h00, SEG_ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [CW-1:0]                  slot_q, slot_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]     shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]          sdp_q, sdp_d;
  logic                           pend_q, pend_d;
  logic [3:0]                     bright_q, bright_d;
  logic                           blz_q, blz_d;
  logic [7:0]                     seg_q, seg_d;
  logic [NUM_DIGITS-1:0]          dig_q, dig_d;

  logic                           slot_start, slot_end, frame;
  logic [3:0]                     bright_eff;
  logic                           blz_eff;
  logic [EW-1:0]                  on_len;
  logic                           lit;
  logic [NUM_DIGITS-1:0]          dig_on;
  logic [NUM_DIGITS:1]            hi_zero;
  logic [NUM_DIGITS-1:0]          lz_blank;
  logic [NUM_DIGITS-1:0][7:0]     pat;

  assign slot_start = (slot_q == '0);
  assign slot_end   = (slot_q == SLOT_LAST);
  assign frame      = slot_end && (idx_q == IDX_LAST);

  // Slot-start samples are used directly in the first cycle so a zero
  // guard length still sees this slot's brightness and blanking mode.
  assign bright_eff = slot_start ? brightness_i : bright_q;
  assign blz_eff    = slot_start ? blank_lz_i   : blz_q;

  // hi_zero[k]: shadow digits k..NUM_DIGITS-1 are all zero.
  assign hi_zero[NUM_DIGITS] = 1'b1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    if (k == 0) begin : g_lsd
      assign lz_blank[k] = 1'b0;
    end else begin : g_upper
      assign hi_zero[k]  = (shadow_q[k] == 4'h0) && hi_zero[k+1];
      assign lz_blank[k] = blz_eff && hi_zero[k];
    end

    seg7_hex_decode u_dec (
      .nib_i   (shadow_q[k]),
      .dp_i    (sdp_q[k]),
      .blank_i (lz_blank[k]),
      .pat_o   (pat[k])
    );
  end

  // Lit window: BLANK_CYCLES <= slot < BLANK_CYCLES + ON_UNIT*(level+1).
  assign on_len = EW'(ON_UNIT) * EW'({1'b0, bright_eff} + 5'd1);
  assign lit    = ({1'b0, slot_q} >= EW'(BLANK_CYCLES)) &&
                  ({1'b0, slot_q} <  (EW'(BLANK_CYCLES) + on_len));

  always_comb begin
    slot_d   = slot_end ? '0 : slot_q + CW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    pend_d   = pend_q | load_i;
    bright_d = bright_eff;
    blz_d    = blz_eff;

    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // Shadow only moves on the frame boundary, so a frame is never torn.
    if (frame && pend_d) begin
      shadow_d = digits_i;
      sdp_d    = dp_i;
      pend_d   = 1'b0;
    end
  end

  always_comb begin
    dig_on = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    dig_d  = DIG_ACTIVE_LOW ? ~dig_on : dig_on;
    seg_d  = lit ? pol8(pat[idx_q], SEG_ACTIVE_LOW) : SEG_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      pend_q   <= 1'b0;
      bright_q <= '0;
      blz_q    <= 1'b0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
    end else begin
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      pend_q   <= pend_d;
      bright_q <= bright_d;
      blz_q    <= blz_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
    end
  end

  assign seg_o   = seg_q;
  assign dig_o   = dig_q;
  assign frame_o = frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random
// traffic against a cycle-count based reference of the display behaviour.
module tb_seg7_scan_driver;

  localparam int N    = 4;
  localparam int P    = 100;
  localparam int BL   = 4;
  localparam int UNIT = 6;
  localparam int FR   = N * P;

  localparam logic [6:0] TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic        load_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic [3:0]  brightness_i = '0;
  logic [7:0]  seg_o;
  logic [3:0]  dig_o;
  logic        frame_o;

  int n_chk = 0;
  int n_fail = 0;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_HZ(1000000), .SCAN_HZ(10000), .BLANK_CYCLES(4),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i), .load_i(load_i),
    .blank_lz_i(blank_lz_i), .brightness_i(brightness_i),
    .seg_o(seg_o), .dig_o(dig_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  // Reference: cyc = clock edges since reset release. The state before edge n
  // is slot position n mod P of digit (n/P) mod N; outputs after edge n show it.
  int         cyc = 0;
  logic [3:0] m_sh [N] = '{default: 4'h0};
  logic [3:0] m_dp = '0;
  logic       m_pend = 1'b0;
  int         m_br = 0;
  logic       m_blz = 1'b0;
  logic [7:0] exp_seg = 8'hFF;
  logic [3:0] exp_dig = 4'hF;
  logic       exp_frame;

  assign exp_frame = rst_n && ((cyc % FR) == FR - 1);

  always @(posedge clk or negedge rst_n) begin : model
    int s, d, br;
    logic blz, lz;
    logic [7:0] hi;
    if (!rst_n) begin
      cyc <= 0; m_pend <= 1'b0; m_dp <= '0; m_br <= 0; m_blz <= 1'b0;
      exp_seg <= 8'hFF; exp_dig <= 4'hF;
      for (int k = 0; k < N; k++) m_sh[k] <= 4'h0;
    end else begin
      s   = cyc % P;
      d   = (cyc / P) % N;
      br  = (s == 0) ? int'(brightness_i) : m_br;
      blz = (s == 0) ? blank_lz_i : m_blz;
      m_br  <= br;
      m_blz <= blz;
      if (s >= BL && s < BL + UNIT * (br + 1)) begin
        lz = blz && (d > 0);
        for (int k = d; k < N; k++) if (m_sh[k] != 4'h0) lz = 1'b0;
        hi = {m_dp[d], lz ? 7'h00 : TAB[m_sh[d]]};
        exp_seg <= ~hi;
        exp_dig <= ~(4'b0001 << d);
      end else begin
        exp_seg <= 8'hFF;
        exp_dig <= 4'hF;
      end
      if (s == P - 1 && d == N - 1 && (m_pend || load_i)) begin
        for (int k = 0; k < N; k++) m_sh[k] <= digits_i[4*k +: 4];
        m_dp   <= dp_i;
        m_pend <= 1'b0;
      end else begin
        m_pend <= m_pend | load_i;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic goto_phase(input int m, input int r);
    int guard = 0;
    @(negedge clk);
    while ((cyc % m) != r && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if ((cyc % m) != r) begin
      n_chk++; n_fail++;
      $display("FAIL goto_phase timeout: cyc=%0d, required cyc mod %0d == %0d", cyc, m, r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++; if (seg_o !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h, expected ff", seg_o); end
    n_chk++; if (dig_o !== 4'hF) begin n_fail++; $display("FAIL reset_dig: got %b, expected 1111", dig_o); end
    n_chk++; if (frame_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame: got %b, expected 0", frame_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lit_cnt = 0;
    brightness_i = 4'd15; blank_lz_i = 1'b0; dp_i = 4'h0; digits_i = 16'h1234; load_i = 1'b1;
    repeat (3 * FR) begin
      @(negedge clk);
      load_i = 1'b0;
      n_chk++;
      if ({seg_o, dig_o, frame_o} !== {exp_seg, exp_dig, exp_frame}) begin
        n_fail++;
        $display("FAIL basic_model cyc=%0d: got seg=%h dig=%b frame=%b, expected seg=%h dig=%b frame=%b",
                 cyc, seg_o, dig_o, frame_o, exp_seg, exp_dig, exp_frame);
      end
      if (cyc == 50) begin
        n_chk++; if ({seg_o, dig_o} !== {8'hC0, 4'b1110}) begin n_fail++; $display("FAIL basic_pre_frame: got %h/%b, expected c0/1110", seg_o, dig_o); end
      end
      if (cyc == 450) begin
        n_chk++; if ({seg_o, dig_o} !== {8'h99, 4'b1110}) begin n_fail++; $display("FAIL basic_digit0: got %h/%b, expected 99/1110", seg_o, dig_o); end
      end
      if (cyc == 750) begin
        n_chk++; if ({seg_o, dig_o} !== {8'hF9, 4'b0111}) begin n_fail++; $display("FAIL basic_digit3: got %h/%b, expected f9/0111", seg_o, dig_o); end
      end
      if (cyc == 404) begin
        n_chk++; if (dig_o !== 4'hF) begin n_fail++; $display("FAIL basic_guard: got %b, expected 1111", dig_o); end
      end
      if (cyc == 405) begin
        n_chk++; if (dig_o !== 4'b1110) begin n_fail++; $display("FAIL basic_first_lit: got %b, expected 1110", dig_o); end
      end
      if (cyc >= 401 && cyc <= 500 && dig_o == 4'b1110) lit_cnt++;
    end
    n_chk++; if (lit_cnt != 96) begin n_fail++; $display("FAIL basic_lit_len: got %0d, expected 96", lit_cnt); end
  endtask

  task automatic test_brightness();
    int cnt;
    int lv [3];
    lv[0] = 0; lv[1] = 7; lv[2] = int'($urandom_range(1, 14));
    goto_phase(FR, 0);
    for (int i = 0; i < 3; i++) begin
      brightness_i = 4'(lv[i]);
      cnt = 0;
      repeat (FR) begin
        @(negedge clk);
        n_chk++;
        if ({seg_o, dig_o, frame_o} !== {exp_seg, exp_dig, exp_frame}) begin
          n_fail++;
          $display("FAIL bright_model cyc=%0d: got seg=%h dig=%b frame=%b, expected seg=%h dig=%b frame=%b",
                   cyc, seg_o, dig_o, frame_o, exp_seg, exp_dig, exp_frame);
        end
        if (dig_o !== 4'hF) cnt++;
      end
      n_chk++;
      if (cnt != N * UNIT * (lv[i] + 1)) begin
        n_fail++; $display("FAIL bright_frame_lit level %0d: got %0d, expected %0d", lv[i], cnt, N * UNIT * (lv[i] + 1));
      end
    end
    brightness_i = 4'd0;
    for (int sl = 0; sl < 2; sl++) begin
      cnt = 0;
      repeat (P) begin
        @(negedge clk);
        n_chk++;
        if ({seg_o, dig_o, frame_o} !== {exp_seg, exp_dig, exp_frame}) begin
          n_fail++;
          $display("FAIL bright_mid_model cyc=%0d: got seg=%h dig=%b, expected seg=%h dig=%b",
                   cyc, seg_o, dig_o, exp_seg, exp_dig);
        end
        if ((cyc % P) == 50) brightness_i = 4'd15;
        if (dig_o !== 4'hF) cnt++;
      end
      n_chk++;
      if (cnt != ((sl == 0) ? 6 : 96)) begin
        n_fail++; $display("FAIL bright_mid_slot%0d: got %0d, expected %0d", sl, cnt, (sl == 0) ? 6 : 96);
      end
    end
  endtask

  task automatic test_blanking();
    int s0, r;
    goto_phase(FR, 0);
    s0 = cyc;
    digits_i = 16'h0050; dp_i = 4'b1000; blank_lz_i = 1'b1; brightness_i = 4'd15; load_i = 1'b1;
    repeat (3 * FR) begin
      @(negedge clk);
      r = cyc - s0;
      load_i = 1'b0;
      n_chk++;
      if ({seg_o, dig_o, frame_o} !== {exp_seg, exp_dig, exp_frame}) begin
        n_fail++;
        $display("FAIL blank_model cyc=%0d: got seg=%h dig=%b frame=%b, expected seg=%h dig=%b frame=%b",
                 cyc, seg_o, dig_o, frame_o, exp_seg, exp_dig, exp_frame);
      end
      if (r == 450) begin n_chk++; if (seg_o !== 8'hC0) begin n_fail++; $display("FAIL blank_d0: got %h, expected c0", seg_o); end end
      if (r == 550) begin n_chk++; if (seg_o !== 8'h92) begin n_fail++; $display("FAIL blank_d1: got %h, expected 92", seg_o); end end
      if (r == 650) begin
        n_chk++; if ({seg_o, dig_o} !== {8'hFF, 4'b1011}) begin n_fail++; $display("FAIL blank_d2: got %h/%b, expected ff/1011", seg_o, dig_o); end
      end
      if (r == 750) begin n_chk++; if (seg_o !== 8'h7F) begin n_fail++; $display("FAIL blank_d3_dp: got %h, expected 7f", seg_o); end end
      if (r == 800) blank_lz_i = 1'b0;
      if (r == 1050) begin n_chk++; if (seg_o !== 8'hC0) begin n_fail++; $display("FAIL noblank_d2: got %h, expected c0", seg_o); end end
      if (r == 1150) begin n_chk++; if (seg_o !== 8'h40) begin n_fail++; $display("FAIL noblank_d3: got %h, expected 40", seg_o); end end
    end
  endtask

  task automatic test_load_order();
    int s0, r;
    logic saw1 = 1'b0;
    goto_phase(FR, 0);
    s0 = cyc;
    blank_lz_i = 1'b0; brightness_i = 4'd15; dp_i = 4'($urandom);
    repeat (3 * FR) begin
      @(negedge clk);
      r = cyc - s0;
      n_chk++;
      if ({seg_o, dig_o, frame_o} !== {exp_seg, exp_dig, exp_frame}) begin
        n_fail++;
        $display("FAIL load_model cyc=%0d: got seg=%h dig=%b frame=%b, expected seg=%h dig=%b frame=%b",
                 cyc, seg_o, dig_o, frame_o, exp_seg, exp_dig, exp_frame);
      end
      if (dig_o !== 4'hF && seg_o[6:0] === 7'h79) saw1 = 1'b1;
      if (r == 450) begin n_chk++; if (seg_o[6:0] !== 7'h24) begin n_fail++; $display("FAIL load_late_d0: got %h, expected 24", seg_o[6:0]); end end
      if (r == 750) begin n_chk++; if (seg_o[6:0] !== 7'h24) begin n_fail++; $display("FAIL load_late_d3: got %h, expected 24", seg_o[6:0]); end end
      if (r == 799) begin n_chk++; if (frame_o !== 1'b1) begin n_fail++; $display("FAIL load_frame_cycle: got %b, expected 1", frame_o); end end
      if (r == 850) begin n_chk++; if (seg_o[6:0] !== 7'h30) begin n_fail++; $display("FAIL load_coincident: got %h, expected 30", seg_o[6:0]); end end
      load_i = 1'b0;
      if (r == 150) begin digits_i = 16'h1111; load_i = 1'b1; end
      if (r == 397) begin digits_i = 16'h2222; load_i = 1'b1; end
      if (r == 799) begin digits_i = 16'h3333; load_i = 1'b1; end
    end
    load_i = 1'b0;
    n_chk++; if (saw1) begin n_fail++; $display("FAIL load_no_1111: got displayed 1, expected never"); end
  endtask

  task automatic test_reset_mid();
    brightness_i = 4'd15; blank_lz_i = 1'b0;
    goto_phase(P, 50);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({seg_o, dig_o, frame_o} !== {8'hFF, 4'hF, 1'b0}) begin
      n_fail++; $display("FAIL rstmid_async: got %h/%b/%b, expected ff/1111/0", seg_o, dig_o, frame_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FR + 100) begin
      @(negedge clk);
      n_chk++;
      if ({seg_o, dig_o, frame_o} !== {exp_seg, exp_dig, exp_frame}) begin
        n_fail++;
        $display("FAIL rstmid_model cyc=%0d: got seg=%h dig=%b frame=%b, expected seg=%h dig=%b frame=%b",
                 cyc, seg_o, dig_o, frame_o, exp_seg, exp_dig, exp_frame);
      end
      if (cyc == 4) begin n_chk++; if (dig_o !== 4'hF) begin n_fail++; $display("FAIL rstmid_guard: got %b, expected 1111", dig_o); end end
      if (cyc == 5) begin
        n_chk++; if ({seg_o, dig_o} !== {8'hC0, 4'b1110}) begin n_fail++; $display("FAIL rstmid_restart: got %h/%b, expected c0/1110", seg_o, dig_o); end
      end
    end
  endtask

  task automatic test_frames();
    logic [3:0] vals [16];
    int s0, r, last = -1, gaps = 0;
    int r0 = int'($urandom_range(0, 15));
    for (int f = 0; f < 16; f++) vals[f] = 4'((f + r0) % 16);
    blank_lz_i = 1'b0; brightness_i = 4'($urandom);
    goto_phase(FR, 0);
    s0 = cyc;
    digits_i = {12'($urandom), vals[0]}; dp_i = 4'($urandom); load_i = 1'b1;
    repeat (17 * FR) begin
      @(negedge clk);
      r = cyc - s0;
      n_chk++;
      if ({seg_o, dig_o, frame_o} !== {exp_seg, exp_dig, exp_frame}) begin
        n_fail++;
        $display("FAIL frames_model cyc=%0d: got seg=%h dig=%b frame=%b, expected seg=%h dig=%b frame=%b",
                 cyc, seg_o, dig_o, frame_o, exp_seg, exp_dig, exp_frame);
      end
      if (frame_o === 1'b1) begin
        if (last >= 0 && gaps < 5) begin
          gaps++;
          n_chk++; if (cyc - last != FR) begin n_fail++; $display("FAIL frame_spacing: got %0d, expected %0d", cyc - last, FR); end
        end
        last = cyc;
      end
      if ((r % FR) == 6 && r / FR >= 1 && r / FR <= 16) begin
        n_chk++;
        if (seg_o[6:0] !== ~TAB[vals[r / FR - 1]]) begin
          n_fail++; $display("FAIL decode_%h: got %h, expected %h", vals[r / FR - 1], seg_o[6:0], ~TAB[vals[r / FR - 1]]);
        end
      end
      load_i = 1'b0;
      if ((r % FR) == 0 && r / FR < 16) begin
        digits_i = {12'($urandom), vals[r / FR]}; dp_i = 4'($urandom); load_i = 1'b1;
      end
    end
    load_i = 1'b0;
    n_chk++; if (gaps != 5) begin n_fail++; $display("FAIL frame_count: got %0d gaps, expected 5", gaps); end
  endtask

  task automatic test_random();
    repeat (3000) begin
      @(negedge clk);
      n_chk++;
      if ({seg_o, dig_o, frame_o} !== {exp_seg, exp_dig, exp_frame}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d: got seg=%h dig=%b frame=%b, expected seg=%h dig=%b frame=%b",
                 cyc, seg_o, dig_o, frame_o, exp_seg, exp_dig, exp_frame);
      end
      load_i = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++) digits_i[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        dp_i = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) begin
        brightness_i = 4'($urandom);
        blank_lz_i   = 1'($urandom);
      end
    end
    load_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_brightness();
    test_blanking();
    test_load_order();
    test_reset_mid();
    test_frames();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
